// File: rtl/fma16_pkg.sv
// Shared fp16 constants and encodings for the fma16 datapath and its rounding stage.
package fma16_pkg;

    localparam int unsigned BIAS = 15;
    localparam logic [15:0] INF  = 16'h7C00;
    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] MAXF = 16'h7BFF;

    typedef enum logic [1:0] {
        RZ  = 2'b00,
        RNE = 2'b01,
        RP  = 2'b10,
        RN  = 2'b11
    } roundmode_t;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'b00,
        SP_INF    = 2'b01,
        SP_NAN    = 2'b10,
        SP_RSVD   = 2'b11
    } special_t;

endpackage

// File: rtl/fma16_round_lzc22.sv
// Combinational 22-bit leading-zero counter; an all-zero input yields 22.
module lzc22 (
    input  logic [21:0] a,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd22;
        // Ascending scan: the highest set bit is the last to write.
        for (int unsigned i = 0; i < 22; i++) begin
            if (a[i]) count = 5'(21 - i);
        end
    end

endmodule

// File: rtl/fma16_round.sv
// Two-stage fp16 normalize/round/pack stage for the fma16 datapath.
// Define FMA16_ROUND_FLAGS_EN to build the {overflow, underflow, inexact} flag registers.
module fma16_round
    import fma16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exp,
    input  logic [21:0] in_man,
    input  logic [1:0]  in_special,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [2:0]  flags
);

    localparam logic signed [8:0] EMAX = 9'(2 * BIAS + 1);

    logic v1, v2, en1, en2;

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v2;

    // S1: leading-one detect, normalize, exponent adjust
    logic [4:0]         lzc;
    logic [21:0]        norm;
    logic signed [8:0]  exp0;

    lzc22 u_lzc (
        .a     (in_man),
        .count (lzc)
    );

    // Shifting left by lzc puts the leading one at bit 21; e = in_exp + p - 20 with p = 21 - lzc.
    assign norm = in_man << lzc;
    assign exp0 = $signed({{2{in_exp[6]}}, in_exp}) + 9'sd1 - $signed({4'b0, lzc});

    logic              s1_sign, s1_guard, s1_sticky, s1_zero;
    logic signed [8:0] s1_exp;
    logic [10:0]       s1_sig;
    special_t          s1_special;
    roundmode_t        s1_rm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            s1_sign    <= in_sign;
            s1_exp     <= exp0;
            s1_sig     <= norm[21:11];
            s1_guard   <= norm[10];
            s1_sticky  <= |norm[9:0];
            s1_zero    <= (in_man == '0);
            s1_special <= special_t'(in_special);
            s1_rm      <= roundmode_t'(roundmode);
        end
    end

    // S2: round, overflow/underflow, pack
    logic              inc, is_special, is_ovf, is_unf;
    logic [11:0]       sum;
    logic signed [8:0] exp_rnd;
    logic [9:0]        frac;
    logic [15:0]       res_next;

    always_comb begin
        inc = 1'b0;
        unique case (s1_rm)
            RZ:  inc = 1'b0;
            RNE: inc = s1_guard & (s1_sticky | s1_sig[0]);
            RP:  inc = !s1_sign & (s1_guard | s1_sticky);
            RN:  inc = s1_sign & (s1_guard | s1_sticky);
            default: inc = 1'b0;
        endcase
        sum     = {1'b0, s1_sig} + {11'b0, inc};
        exp_rnd = sum[11] ? s1_exp + 9'sd1 : s1_exp;
        frac    = sum[11] ? '0 : sum[9:0];

        is_special = (s1_special != SP_NORMAL);
        is_ovf     = !is_special && !s1_zero && (exp_rnd >= EMAX);
        is_unf     = !is_special && !s1_zero && (exp_rnd <= 9'sd0);

        res_next = {s1_sign, exp_rnd[4:0], frac};
        if (s1_special == SP_INF) begin
            res_next = {s1_sign, INF[14:0]};
        end else if (is_special) begin
            res_next = QNAN;
        end else if (s1_zero || is_unf) begin
            res_next = {s1_sign, 15'b0};
        end else if (is_ovf) begin
            unique case (s1_rm)
                RZ:  res_next = {s1_sign, MAXF[14:0]};
                RNE: res_next = {s1_sign, INF[14:0]};
                RP:  res_next = s1_sign ? {1'b1, MAXF[14:0]} : INF;
                RN:  res_next = s1_sign ? {1'b1, INF[14:0]} : MAXF;
                default: res_next = {s1_sign, INF[14:0]};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
        end else if (en2 && v1) begin
            result <= res_next;
        end
    end

`ifdef FMA16_ROUND_FLAGS_EN
    logic [2:0] flags_next;

    always_comb begin
        flags_next = {is_ovf, is_unf,
                      is_ovf | is_unf | ((s1_guard | s1_sticky) & !is_special & !s1_zero)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else if (en2 && v1) begin
            flags <= flags_next;
        end
    end
`else
    assign flags = '0;
`endif

endmodule

// File: tb/tb_fma16_round.sv
// Scoreboard bench for fma16_round: randomized and directed inputs against an arithmetic reference model.
module tb_fma16_round;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_sign, out_valid, out_ready;
    logic [6:0]  in_exp;
    logic [21:0] in_man;
    logic [1:0]  in_special, roundmode;
    logic [15:0] result;
    logic [2:0]  flags;

    fma16_round dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .in_special (in_special),
        .roundmode  (roundmode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  flg;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   check_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer rounding of in_man * 2^(in_exp-35) to 11 significant bits.
    function automatic logic [18:0] model(input logic s, input logic [6:0] e7, input logic [21:0] m,
                                          input logic [1:0] sp, input logic [1:0] rm);
        int          p, e;
        longint      keep, rem, half;
        bit          inc, inexact;
        logic [15:0] r;
        logic [2:0]  fl;
        if (sp == 2'b01) return {s, 15'h7C00, 3'b000};
        if (sp != 2'b00) return {16'h7E00, 3'b000};
        if (m == 22'h0) return {s, 15'h0, 3'b000};
        p = 21;
        while (!m[p]) p--;
        e = int'($signed(e7)) + p - 20;
        if (p >= 10) begin
            keep = longint'(m) >> (p - 10);
            rem  = longint'(m) - (keep << (p - 10));
            half = (p >= 11) ? (64'sd1 <<< (p - 11)) : 64'sd0;
        end else begin
            keep = longint'(m) << (10 - p);
            rem  = 0;
            half = 0;
        end
        case (rm)
            2'b00:   inc = 1'b0;
            2'b01:   inc = (rem != 0) && ((rem > half) || (rem == half && keep[0]));
            2'b10:   inc = !s && (rem != 0);
            default: inc = s && (rem != 0);
        endcase
        if (inc) keep++;
        if (keep == 2048) begin
            keep = 1024;
            e++;
        end
        inexact = (rem != 0);
        if (e >= 31) begin
            case (rm)
                2'b00:   r = {s, 15'h7BFF};
                2'b01:   r = {s, 15'h7C00};
                2'b10:   r = s ? 16'hFBFF : 16'h7C00;
                default: r = s ? 16'hFC00 : 16'h7BFF;
            endcase
            fl = 3'b101;
        end else if (e <= 0) begin
            r  = {s, 15'h0};
            fl = 3'b011;
        end else begin
            r  = {s, e[4:0], keep[9:0]};
            fl = {2'b00, inexact};
        end
`ifndef FMA16_ROUND_FLAGS_EN
        fl = 3'b000;
`endif
        return {r, fl};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic send(input logic s, input logic [6:0] e, input logic [21:0] m,
                        input logic [1:0] sp, input logic [1:0] rm);
        logic [18:0] x;
        bit          done;
        done       = 1'b0;
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp     = e;
        in_man     = m;
        in_special = sp;
        roundmode  = rm;
        x          = model(s, e, m, sp, rm);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{res: x[18:3], flg: x[2:0], acc: cyc});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end
    endtask

    task automatic send_rand();
        logic [31:0] mask;
        logic [6:0]  e;
        logic [1:0]  sp;
        mask = (32'h1 << $urandom_range(0, 22)) - 32'h1;
        e    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 50));
        sp   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send(1'($urandom), e, 22'($urandom & mask), sp, 2'($urandom));
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
        end
    endtask

    // Monitor: pops one expectation per output transfer and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_res;
    logic [2:0]  prev_flg;

    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || result !== prev_res || flags !== prev_flg) begin
                    errors++;
                    $display("FAIL hold: valid=%b result=%h flags=%b expected valid=1 result=%h flags=%b",
                             out_valid, result, flags, prev_res, prev_flg);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: result=%h with no pending input", result);
                end else begin
                    x = sb.pop_front();
                    if (result !== x.res || flags !== x.flg) begin
                        errors++;
                        $display("FAIL result: got %h flags %b expected %h flags %b",
                                 result, flags, x.res, x.flg);
                    end
                    if (check_lat) begin
                        checks++;
                        if (cyc - x.acc != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d expected 2", cyc - x.acc);
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_flg   = flags;
        end
    end

    bit rand_done = 1'b0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
        in_special = '0; roundmode = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'h0);
        chk("reset_flags", 32'(flags), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed values, out_ready held high so latency is exactly 2.
        check_lat = 1'b1;
        send(0, 7'd15, 22'h100000, 2'b00, 2'b01);
        send(0, 7'd15, 22'h300000, 2'b00, 2'b01);
        send(0, 7'd15, 22'h100600, 2'b00, 2'b01);
        send(0, 7'd15, 22'h100600, 2'b00, 2'b00);
        send(0, 7'd15, 22'h100600, 2'b00, 2'b10);
        send(1, 7'd15, 22'h100600, 2'b00, 2'b11);
        send(0, 7'd31, 22'h100000, 2'b00, 2'b01);
        send(0, 7'd31, 22'h100000, 2'b00, 2'b00);
        send(1, 7'd31, 22'h100000, 2'b00, 2'b10);
        send(0, 7'd31, 22'h100000, 2'b00, 2'b11);
        send(0, 7'd0,  22'h100000, 2'b00, 2'b01);
        send(0, 7'd15, 22'h1FFE00, 2'b00, 2'b01);
        send(1, 7'd30, 22'h1FFE00, 2'b00, 2'b01);
        send(0, 7'd33, 22'h000005, 2'b00, 2'b01);
        send(1, 7'h7F, 22'h3FFFFF, 2'b00, 2'b10);
        send(1, 7'd3,  22'h123456, 2'b01, 2'b01);
        send(0, 7'd3,  22'h123456, 2'b10, 2'b01);
        send(1, 7'd3,  22'h123456, 2'b11, 2'b01);
        send(1, 7'd20, 22'h000000, 2'b00, 2'b11);
        drain();
        check_lat = 1'b0;

        // Backpressure: two accepts, then in_ready must drop until out_ready rises.
        out_ready = 1'b0;
        send(0, 7'd16, 22'h100001, 2'b00, 2'b01);
        send(1, 7'd17, 22'h2ABCDE, 2'b00, 2'b11);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 7'd18; in_man = 22'h155555; roundmode = 2'b10;
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(0, 7'd18, 22'h155555, 2'b00, 2'b10);
        drain();

        // Reset mid-cycle with both stages full.
        out_ready = 1'b0;
        send(0, 7'd15, 22'h100600, 2'b00, 2'b01);
        send(1, 7'd31, 22'h100000, 2'b00, 2'b01);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_result", 32'(result), 32'h0);
        chk("midreset_flags", 32'(flags), 32'h0);
        sb.delete();
        #4;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postreset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Random stimulus under random backpressure.
        fork
            begin
                for (int i = 0; i < 400; i++) send_rand();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random stimulus at full throughput.
        check_lat = 1'b1;
        for (int i = 0; i < 200; i++) send_rand();
        drain();
        check_lat = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
